i2lbs_scan_controller: RTL and testbench
========================================

// Module: i2lbs_scan_controller
//
// PURPOSE
// - Sequences the integral-image line-buffer memory (I2LBS) for one camera frame.
// - Accepts the camera pixel stream (valid/ready) and forwards it as write-enabled pixels.
// - Tracks the column/row raster position and flushes the buffer at each frame start.
// - Presents each complete INTEGRAL_WIDTH x INTEGRAL_HEIGHT window to the classifier,
//   stalling the stream until the window is acknowledged.
//
// PARAMETERS
// - DATA_WIDTH_12        12  pixel width and width of the position counters
// - INTEGRAL_WIDTH       3   window width in pixels
// - INTEGRAL_HEIGHT      3   window height in pixels
// - FRAME_CAMERA_WIDTH   10  pixels per row
// - FRAME_CAMERA_HEIGHT  10  rows per frame
//
// PORTS
// - clk_os          in   1   system clock, all logic on rising edge
// - reset_os        in   1   synchronous, active-high reset
// - i_frame_start   in   1   single-cycle pulse: start (or restart) a frame
// - i_pixel         in   12  camera pixel
// - i_pixel_valid   in   1   i_pixel is valid
// - o_pixel_ready   out  1   registered; pixel accepted when valid & ready
// - o_mem_reset     out  1   single-cycle flush pulse to the I2LBS memory
//                            (ORed with reset_os at the memory)
// - o_mem_wen       out  1   write enable to the I2LBS memory
// - o_mem_pixel     out  12  pixel to the I2LBS memory
// - o_window_valid  out  1   window at (o_window_x, o_window_y) is present at the memory output
// - o_window_x      out  12  window top-left column
// - o_window_y      out  12  window top-left row
// - i_window_ack    in   1   classifier consumed the window
// - o_frame_done    out  1   single-cycle pulse when the last window of a frame is acked
// - o_busy          out  1   high in every state except IDLE
//
// BEHAVIOUR
// - Reset values: all outputs 0, FSM = IDLE, col = row = 0.
// - FSM states:
//   - IDLE: ready = 0. On i_frame_start -> FLUSH.
//   - FLUSH: one cycle, o_mem_reset = 1, col = row = 0.
//     Next cycle -> STREAM with ready = 1.
//   - STREAM, on accept at edge N:
//     - o_mem_pixel <= i_pixel and o_mem_wen = 1 during cycle N+1 (one-cycle latency).
//     - col increments; at FRAME_CAMERA_WIDTH-1 it wraps to 0 and row increments.
//     - The accepted pixel completes a window when col >= INTEGRAL_WIDTH-1 and
//       row >= INTEGRAL_HEIGHT-1. If so:
//       - ready is 0 from cycle N+1;
//       - x/y = col-INTEGRAL_WIDTH+1 / row-INTEGRAL_HEIGHT+1 are latched;
//       - FSM -> HOLD.
//     - Other accepted pixels keep ready = 1, giving one pixel per cycle.
//   - HOLD: o_window_valid = 1 from cycle N+2, held with x/y stable until i_window_ack.
//     On ack, valid drops next cycle:
//     - if the window was the frame's last pixel (col FW-1, row FH-1) -> DONE;
//     - otherwise -> STREAM with ready = 1.
//   - DONE: one cycle, o_frame_done = 1, then -> IDLE.
// - i_window_ack outside HOLD, or in HOLD before o_window_valid is high, is ignored.
// - An ack in the first valid cycle is honoured.
// - i_pixel_valid while ready = 0 is ignored; the pixel is not consumed.
// - i_frame_start in any non-IDLE state aborts the frame:
//   - -> FLUSH; o_window_valid clears next cycle;
//   - no o_frame_done for the aborted frame.
// - i_frame_start in the same cycle as an accept: the abort wins and the pixel is dropped (no wen).
// - reset_os mid-frame: immediate return to the reset values on the next edge.
// - Counters never exceed FRAME_CAMERA_WIDTH-1 / FRAME_CAMERA_HEIGHT-1.
// - Pixels after the last one are not accepted (ready = 0 until the next FLUSH).
// - Windows per frame: (FW-INTEGRAL_WIDTH+1) * (FH-INTEGRAL_HEIGHT+1).
//
// CONFIGURATION
// - I2LBS_STRIDE2_EN defined: a window is emitted only when both x and y are even.
//   - Other completing pixels behave as non-window pixels (no HOLD).
//   - The frame's last pixel always goes through DONE; it passes through HOLD only if its x and y are even.
// - Not defined: every window position is emitted (stride 1).
//
// TESTING (defaults W = H = 3, FW = FH = 10)
// - Reset: assert reset_os for 2 cycles mid-stream -> all outputs 0, next frame starts cleanly.
// - Full frame: frame_start, 100 back-to-back pixels, ack tied high
//   -> 64 windows, first (0,0) after the 23rd pixel, last (7,7), exactly one o_frame_done.
// - Stall: ack delayed 5 cycles on window (3,4)
//   -> ready = 0 and wen = 0 for the full hold, x/y stable, valid drops the cycle after ack.
// - Bursty source: valid toggling 1/0
//   -> counters advance only on accept, o_mem_wen count equals the accept count (100).
// - Abort: frame_start after 40 pixels -> one o_mem_reset pulse, col = row = 0,
//   no o_frame_done, the following full frame gives 64 windows.
// - Stride build (I2LBS_STRIDE2_EN): full frame -> 16 windows at x,y in {0,2,4,6}, one o_frame_done.

Source files
------------

// File: rtl/i2lbs_scan_controller.sv
// rtl/i2lbs_scan_controller.sv - I2LBS frame sequencer: pixel forwarding, raster tracking, window handshake
// Optional build macro I2LBS_STRIDE2_EN: emit only windows whose top-left x and y are both even.
module i2lbs_scan_controller #(
    parameter int DATA_WIDTH_12       = 12,
    parameter int INTEGRAL_WIDTH      = 3,
    parameter int INTEGRAL_HEIGHT     = 3,
    parameter int FRAME_CAMERA_WIDTH  = 10,
    parameter int FRAME_CAMERA_HEIGHT = 10
) (
    input  logic                     clk_os,
    input  logic                     reset_os,
    input  logic                     i_frame_start,
    input  logic [DATA_WIDTH_12-1:0] i_pixel,
    input  logic                     i_pixel_valid,
    output logic                     o_pixel_ready,
    output logic                     o_mem_reset,
    output logic                     o_mem_wen,
    output logic [DATA_WIDTH_12-1:0] o_mem_pixel,
    output logic                     o_window_valid,
    output logic [DATA_WIDTH_12-1:0] o_window_x,
    output logic [DATA_WIDTH_12-1:0] o_window_y,
    input  logic                     i_window_ack,
    output logic                     o_frame_done,
    output logic                     o_busy
);

    localparam logic [DATA_WIDTH_12-1:0] COL_LAST = DATA_WIDTH_12'(FRAME_CAMERA_WIDTH - 1);
    localparam logic [DATA_WIDTH_12-1:0] ROW_LAST = DATA_WIDTH_12'(FRAME_CAMERA_HEIGHT - 1);
    localparam logic [DATA_WIDTH_12-1:0] WIN_W_M1 = DATA_WIDTH_12'(INTEGRAL_WIDTH - 1);
    localparam logic [DATA_WIDTH_12-1:0] WIN_H_M1 = DATA_WIDTH_12'(INTEGRAL_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_STREAM = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                   state;
    logic [DATA_WIDTH_12-1:0] col;
    logic [DATA_WIDTH_12-1:0] row;
    logic                     hold_last;

    logic                     accept;
    logic                     last_pix;
    logic                     completes;
    logic                     emit;
    logic [DATA_WIDTH_12-1:0] win_x;
    logic [DATA_WIDTH_12-1:0] win_y;

    assign accept    = i_pixel_valid && o_pixel_ready;
    assign last_pix  = (col == COL_LAST) && (row == ROW_LAST);
    assign completes = (col >= WIN_W_M1) && (row >= WIN_H_M1);
    assign win_x     = col - WIN_W_M1;
    assign win_y     = row - WIN_H_M1;

`ifdef I2LBS_STRIDE2_EN
    assign emit = completes && !win_x[0] && !win_y[0];
`else
    assign emit = completes;
`endif

    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state          <= S_IDLE;
            col            <= '0;
            row            <= '0;
            hold_last      <= 1'b0;
            o_pixel_ready  <= 1'b0;
            o_mem_reset    <= 1'b0;
            o_mem_wen      <= 1'b0;
            o_mem_pixel    <= '0;
            o_window_valid <= 1'b0;
            o_window_x     <= '0;
            o_window_y     <= '0;
            o_frame_done   <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            o_mem_reset  <= 1'b0;
            o_mem_wen    <= 1'b0;
            o_frame_done <= 1'b0;
            // A frame start restarts from any state and drops a coincident pixel.
            if (i_frame_start) begin
                state          <= S_FLUSH;
                o_mem_reset    <= 1'b1;
                o_pixel_ready  <= 1'b0;
                o_window_valid <= 1'b0;
                col            <= '0;
                row            <= '0;
                o_busy         <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_FLUSH: begin
                        state         <= S_STREAM;
                        o_pixel_ready <= 1'b1;
                    end
                    S_STREAM: begin
                        if (accept) begin
                            o_mem_wen   <= 1'b1;
                            o_mem_pixel <= i_pixel;
                            hold_last   <= last_pix;
                            // Counters park on the last pixel so they never leave the frame.
                            if (!last_pix) begin
                                if (col == COL_LAST) begin
                                    col <= '0;
                                    row <= row + 1'b1;
                                end else begin
                                    col <= col + 1'b1;
                                end
                            end
                            if (emit) begin
                                o_pixel_ready <= 1'b0;
                                o_window_x    <= win_x;
                                o_window_y    <= win_y;
                                state         <= S_HOLD;
                            end else if (last_pix) begin
                                o_pixel_ready <= 1'b0;
                                o_frame_done  <= 1'b1;
                                state         <= S_DONE;
                            end
                        end
                    end
                    S_HOLD: begin
                        // First HOLD cycle lets the memory output settle before valid.
                        if (!o_window_valid) begin
                            o_window_valid <= 1'b1;
                        end else if (i_window_ack) begin
                            o_window_valid <= 1'b0;
                            if (hold_last) begin
                                o_frame_done <= 1'b1;
                                state        <= S_DONE;
                            end else begin
                                o_pixel_ready <= 1'b1;
                                state         <= S_STREAM;
                            end
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2lbs_scan_controller.sv
// tb/tb_i2lbs_scan_controller.sv - randomized bench for i2lbs_scan_controller against a raster-index model
module tb_i2lbs_scan_controller;

    localparam int FW = 10;
    localparam int FH = 10;
    localparam int IW = 3;
    localparam int IH = 3;
`ifdef I2LBS_STRIDE2_EN
    localparam int NWIN = 16;
    localparam int LAST_XY = 6;
`else
    localparam int NWIN = 64;
    localparam int LAST_XY = 7;
`endif

    logic        clk = 1'b0;
    logic        reset_os = 1'b1;
    logic        i_frame_start = 1'b0;
    logic [11:0] i_pixel = '0;
    logic        i_pixel_valid = 1'b0;
    logic        i_window_ack = 1'b0;
    logic        o_pixel_ready, o_mem_reset, o_mem_wen, o_window_valid, o_frame_done, o_busy;
    logic [11:0] o_mem_pixel, o_window_x, o_window_y;

    i2lbs_scan_controller dut (
        .clk_os(clk), .reset_os(reset_os), .i_frame_start(i_frame_start),
        .i_pixel(i_pixel), .i_pixel_valid(i_pixel_valid), .o_pixel_ready(o_pixel_ready),
        .o_mem_reset(o_mem_reset), .o_mem_wen(o_mem_wen), .o_mem_pixel(o_mem_pixel),
        .o_window_valid(o_window_valid), .o_window_x(o_window_x), .o_window_y(o_window_y),
        .i_window_ack(i_window_ack), .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Model state: expected outputs for the current cycle plus the raster index of accepted pixels.
    logic        e_ready = 0, e_mem_reset = 0, e_wen = 0, e_wv = 0, e_done = 0, e_busy = 0;
    logic [11:0] e_pix = '0, e_x = '0, e_y = '0;
    int          m_k = 0;
    int          m_win = 0;
    bit          m_flush = 0;
    bit          started = 0;
    int          col, row;

    // Statistics over DUT outputs, cleared by the stimulus process between scenarios.
    int win_cnt, wen_cnt, done_cnt, mr_cnt, first_wen, hold34;
    int first_x, first_y, last_x, last_y;
    bit seen_first, prev_wv;

    function automatic bit is_window(input int c, input int r);
        bit ok;
        ok = (c >= IW - 1) && (r >= IH - 1);
`ifdef I2LBS_STRIDE2_EN
        ok = ok && ((c - IW + 1) % 2 == 0) && ((r - IH + 1) % 2 == 0);
`endif
        return ok;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("ready", 32'(o_pixel_ready), 32'(e_ready));
                chk("mem_reset", 32'(o_mem_reset), 32'(e_mem_reset));
                chk("wen", 32'(o_mem_wen), 32'(e_wen));
                if (e_wen) chk("mem_pixel", 32'(o_mem_pixel), 32'(e_pix));
                chk("window_valid", 32'(o_window_valid), 32'(e_wv));
                if (e_wv) begin
                    chk("window_x", 32'(o_window_x), 32'(e_x));
                    chk("window_y", 32'(o_window_y), 32'(e_y));
                end
                chk("frame_done", 32'(o_frame_done), 32'(e_done));
                chk("busy", 32'(o_busy), 32'(e_busy));
            end
            if (o_mem_wen === 1'b1) wen_cnt++;
            if (o_frame_done === 1'b1) done_cnt++;
            if (o_mem_reset === 1'b1) mr_cnt++;
            if (o_window_valid === 1'b1 && o_window_x == 12'd3 && o_window_y == 12'd4) hold34++;
            if (o_window_valid === 1'b1 && !prev_wv) begin
                win_cnt++;
                if (!seen_first) begin
                    seen_first = 1;
                    first_x = int'(o_window_x);
                    first_y = int'(o_window_y);
                    first_wen = wen_cnt;
                end
                last_x = int'(o_window_x);
                last_y = int'(o_window_y);
            end
            prev_wv = (o_window_valid === 1'b1);

            // Advance the model with the inputs that the next rising edge will sample.
            if (reset_os) begin
                e_ready = 0; e_mem_reset = 0; e_wen = 0; e_wv = 0; e_done = 0; e_busy = 0;
                e_pix = '0; e_x = '0; e_y = '0;
                m_k = 0; m_win = 0; m_flush = 0;
                started = 1;
            end else begin
                e_wen = 0;
                if (i_frame_start) begin
                    e_mem_reset = 1; e_ready = 0; e_wv = 0; e_done = 0; e_busy = 1;
                    m_k = 0; m_win = 0; m_flush = 1;
                end else if (m_flush) begin
                    e_mem_reset = 0; e_ready = 1; m_flush = 0;
                end else if (e_done) begin
                    e_done = 0; e_busy = 0;
                end else if (i_pixel_valid && e_ready) begin
                    col = m_k % FW;
                    row = m_k / FW;
                    m_k++;
                    e_wen = 1;
                    e_pix = i_pixel;
                    if (is_window(col, row)) begin
                        e_ready = 0; m_win = 1;
                        e_x = 12'(col - IW + 1);
                        e_y = 12'(row - IH + 1);
                    end else if (m_k == FW * FH) begin
                        e_ready = 0; e_done = 1;
                    end
                end else if (m_win == 1) begin
                    m_win = 2; e_wv = 1;
                end else if (m_win == 2 && i_window_ack) begin
                    e_wv = 0; m_win = 0;
                    if (m_k == FW * FH) e_done = 1;
                    else e_ready = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        win_cnt = 0; wen_cnt = 0; done_cnt = 0; mr_cnt = 0; first_wen = 0; hold34 = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1; seen_first = 0;
    endtask

    // vmode: 0 back-to-back, 1 toggling, 2 random; amode: 0 ack high, 1 random, 2 stall on (3,4).
    task automatic run_frame(input int vmode, input int amode, input int abort_at);
        int  stall;
        bit  v;
        bit  aborted;
        int  cyc;
        stall = 0; v = 1; aborted = 0;
        i_frame_start = 1;
        tick();
        i_frame_start = 0;
        for (cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
            i_pixel = 12'($urandom);
            case (vmode)
                0: i_pixel_valid = 1;
                1: begin i_pixel_valid = v; v = ~v; end
                default: i_pixel_valid = ($urandom_range(0, 9) < 7);
            endcase
            case (amode)
                0: i_window_ack = 1;
                1: i_window_ack = 1'($urandom_range(0, 1));
                default: begin
                    if (o_window_valid && o_window_x == 12'd3 && o_window_y == 12'd4 && stall < 5) begin
                        i_window_ack = 0;
                        stall++;
                    end else begin
                        i_window_ack = 1;
                    end
                end
            endcase
            if (abort_at > 0 && !aborted && wen_cnt >= abort_at) begin
                aborted = 1;
                i_frame_start = 1;
                tick();
                i_frame_start = 0;
                chk("abort_done_none", 32'(done_cnt), 32'd0);
                win_cnt = 0;
                seen_first = 0;
                wen_cnt = 0;
            end else begin
                tick();
            end
        end
        chk("frame_timeout", 32'(done_cnt > 0), 32'd1);
        i_pixel_valid = 0;
        i_window_ack = 0;
        repeat (3) tick();
    endtask

    initial begin
        clear_stats();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", 32'(o_pixel_ready), 32'd0);
        chk("rst_wv", 32'(o_window_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_frame_done), 32'd0);
        chk("rst_wen", 32'(o_mem_wen), 32'd0);
        reset_os = 0;
        tick();

        clear_stats();
        run_frame(0, 0, 0);
        chk("full_windows", 32'(win_cnt), 32'(NWIN));
        chk("full_first_x", 32'(first_x), 32'd0);
        chk("full_first_y", 32'(first_y), 32'd0);
        chk("full_first_after_px", 32'(first_wen), 32'd23);
        chk("full_last_x", 32'(last_x), 32'(LAST_XY));
        chk("full_last_y", 32'(last_y), 32'(LAST_XY));
        chk("full_done", 32'(done_cnt), 32'd1);
        chk("full_wen", 32'(wen_cnt), 32'd100);
        chk("full_mem_reset", 32'(mr_cnt), 32'd1);
        chk("idle_busy", 32'(o_busy), 32'd0);

`ifndef I2LBS_STRIDE2_EN
        clear_stats();
        run_frame(0, 2, 0);
        chk("stall_hold_cycles", 32'(hold34), 32'd6);
        chk("stall_windows", 32'(win_cnt), 32'(NWIN));
`endif

        clear_stats();
        run_frame(1, 1, 0);
        chk("bursty_wen", 32'(wen_cnt), 32'd100);
        chk("bursty_done", 32'(done_cnt), 32'd1);
        chk("bursty_windows", 32'(win_cnt), 32'(NWIN));

        clear_stats();
        run_frame(0, 0, 40);
        chk("abort_mem_reset", 32'(mr_cnt), 32'd2);
        chk("abort_windows", 32'(win_cnt), 32'(NWIN));
        chk("abort_first_x", 32'(first_x), 32'd0);
        chk("abort_first_y", 32'(first_y), 32'd0);
        chk("abort_done", 32'(done_cnt), 32'd1);

        i_frame_start = 1;
        tick();
        i_frame_start = 0;
        i_pixel_valid = 1;
        i_window_ack = 1;
        repeat (30) begin
            i_pixel = 12'($urandom);
            tick();
        end
        reset_os = 1;
        repeat (2) tick();
        @(negedge clk);
        chk("midrst_ready", 32'(o_pixel_ready), 32'd0);
        chk("midrst_wv", 32'(o_window_valid), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_wen", 32'(o_mem_wen), 32'd0);
        reset_os = 0;
        i_pixel_valid = 0;
        tick();
        clear_stats();
        run_frame(2, 1, 0);
        chk("postrst_windows", 32'(win_cnt), 32'(NWIN));
        chk("postrst_done", 32'(done_cnt), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            i_pixel = 12'($urandom);
            i_pixel_valid = ($urandom_range(0, 3) != 0);
            i_window_ack = 1'($urandom_range(0, 1));
            i_frame_start = ($urandom_range(0, 149) == 0);
            tick();
        end
        i_frame_start = 0;
        i_pixel_valid = 0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
